// File: rtl/controlador_tabuleiro.sv
// Board-memory sequencer for piece placement: expands a piece into cells, bounds-checks,
// reads every cell for occupancy and writes the piece only when all cells are free.
module controlador_tabuleiro #(
  parameter int unsigned COORD_W   = 3,
  parameter int unsigned MAX_CELLS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valida,
  input  logic                 jogador,
  input  logic [2:0]           tipo,
  input  logic                 direcao,
  input  logic [COORD_W-1:0]   X1,
  input  logic [COORD_W-1:0]   Y1,
  input  logic                 mem_rd_data,
  output logic [2*COORD_W:0]   mem_addr,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done,
  output logic                 conflito
);

  localparam int unsigned CW    = COORD_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_CELLS + 1);
  localparam logic [CW-1:0] LIM = CW'((1 << COORD_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BOUNDS, S_CHECK, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t              r_state;
  logic                r_jog;
  logic [2:0]          r_tipo;
  logic                r_dir;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_pend;
  logic                r_hit;

  logic [CNT_W-1:0]    w_len;
  logic [CW-1:0]       w_dx;
  logic [CW-1:0]       w_dy;
  logic [CW-1:0]       w_cx;
  logic [CW-1:0]       w_cy;
  logic [2*COORD_W:0]  w_addr;
  logic                w_cur_oob;
  logic                w_oob;
  logic                w_bad;

  // Offset of cell k from the anchor; hidroaviao is the only non-linear shape.
  function automatic logic [2*CW-1:0] cell_offset(input logic [2:0] t, input logic d,
                                                  input logic [CNT_W-1:0] k);
    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    dx = '0;
    dy = '0;
    if (t == 3'd2) begin
      if (k == CNT_W'(1)) begin
        dx = CW'(1);
        dy = CW'(1);
      end else if (k == CNT_W'(2)) begin
        if (d) dy = CW'(2);
        else   dx = CW'(2);
      end
    end else if (d) begin
      dy = CW'(k);
    end else begin
      dx = CW'(k);
    end
    return {dx, dy};
  endfunction

  assign w_len             = CNT_W'(r_tipo) + CNT_W'(1);
  assign {w_dx, w_dy}      = cell_offset(r_tipo, r_dir, r_cnt);
  assign w_cx              = CW'(r_x) + w_dx;
  assign w_cy              = CW'(r_y) + w_dy;
  assign w_cur_oob         = w_cx[CW-1] | w_cy[CW-1];
  assign w_addr            = {r_jog, w_cy[COORD_W-1:0], w_cx[COORD_W-1:0]};
  assign w_bad             = w_oob | (r_tipo > 3'd4);

  // Any cell of the piece beyond the board edge; offsets carry one extra bit so nothing wraps.
  always_comb begin : p_bounds
    logic [CW-1:0] bdx;
    logic [CW-1:0] bdy;
    w_oob = 1'b0;
    for (int k = 0; k < int'(MAX_CELLS); k++) begin
      {bdx, bdy} = cell_offset(r_tipo, r_dir, CNT_W'(k));
      if ((CNT_W'(k) < w_len) &&
          (((CW'(r_x) + bdx) > LIM) || ((CW'(r_y) + bdy) > LIM)))
        w_oob = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_jog    <= 1'b0;
      r_tipo   <= '0;
      r_dir    <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_hit    <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      conflito <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valida) begin
            r_jog    <= jogador;
            r_tipo   <= tipo;
            r_dir    <= direcao;
            r_x      <= X1;
            r_y      <= Y1;
            r_cnt    <= '0;
            busy     <= 1'b1;
            conflito <= 1'b0;
            r_state  <= S_BOUNDS;
          end
        end
        S_BOUNDS: begin
          if (w_bad) begin
            conflito <= 1'b1;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            mem_addr <= w_addr;
            r_cnt    <= CNT_W'(1);
            r_hit    <= w_cur_oob;
            r_pend   <= 1'b0;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Read data lags the address by one cycle, so the first CHECK cycle has nothing to merge.
          r_hit  <= r_hit | (r_pend & mem_rd_data);
          r_pend <= 1'b1;
          if (r_cnt < w_len) begin
            mem_addr <= w_addr;
            r_cnt    <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_hit | mem_rd_data) begin
            conflito <= 1'b1;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            mem_addr <= w_addr;
            mem_we   <= 1'b1;
            r_cnt    <= CNT_W'(1);
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_cnt < w_len) begin
            mem_addr <= w_addr;
            r_cnt    <= r_cnt + CNT_W'(1);
          end else begin
            mem_we   <= 1'b0;
            done     <= 1'b1;
            conflito <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
